// File: rtl/map_view_ctrl.sv
// map_view_ctrl: camera/scroll controller mapping VGA counters to map-space coordinates
//   Ports: clk, rst (sync, active-high); h_cnt/v_cnt/video_on from the VGA sync;
//   frame_start (vblank pulse); player_y (map-space, Y-up); map_x/map_y/map_on
//   (registered, 1-clk latency); cam_y (camera bottom line); scrolling (FSM busy).
//   Option MAP_VIEW_SNAP_EN: camera jumps straight to target each frame.
module map_view_ctrl #(
   parameter int PHY_WIDTH   = 14,
   parameter int MAP_WIDTH_X = 480,
   parameter int MAP_HEIGHT  = 2400,
   parameter int SCREEN_H    = 480,
   parameter int X_OFFSET    = 80,
   parameter int SCROLL_STEP = 4,
   parameter int DEAD_ZONE   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [9:0]           h_cnt,
   input  logic [9:0]           v_cnt,
   input  logic                 video_on,
   input  logic                 frame_start,
   input  logic [PHY_WIDTH-1:0] player_y,
   output logic [PHY_WIDTH-1:0] map_x,
   output logic [PHY_WIDTH-1:0] map_y,
   output logic                 map_on,
   output logic [PHY_WIDTH-1:0] cam_y,
   output logic                 scrolling
);
   localparam logic [PHY_WIDTH-1:0] HALF = PHY_WIDTH'(SCREEN_H / 2);
   localparam logic [PHY_WIDTH-1:0] CMAX = PHY_WIDTH'(MAP_HEIGHT - SCREEN_H);
   localparam logic [PHY_WIDTH-1:0] YTOP = PHY_WIDTH'(SCREEN_H - 1);
   localparam logic [PHY_WIDTH-1:0] XOFF = PHY_WIDTH'(X_OFFSET);
   localparam logic [9:0] XL = 10'(X_OFFSET);
   localparam logic [9:0] XH = 10'(X_OFFSET + MAP_WIDTH_X);
   localparam logic [9:0] SH = 10'(SCREEN_H);
   logic [PHY_WIDTH-1:0] raw, target;
   logic in_win;
   // Camera keeps the player centred vertically, limited to the map extent
   always_comb begin
      raw    = player_y - HALF;
      target = player_y < HALF ? '0 : (raw > CMAX ? CMAX : raw);
      in_win = video_on && h_cnt >= XL && h_cnt < XH && v_cnt < SH;
   end
   // Screen line 0 is the top, map space is Y-up, hence the flip around YTOP
   always_ff @(posedge clk) begin
      if (rst) begin
         map_x  <= '0;
         map_y  <= '0;
         map_on <= 1'b0;
      end else begin
         map_x  <= in_win ? PHY_WIDTH'(h_cnt) - XOFF : '0;
         map_y  <= in_win ? cam_y + YTOP - PHY_WIDTH'(v_cnt) : '0;
         map_on <= in_win;
      end
   end
`ifdef MAP_VIEW_SNAP_EN
   assign scrolling = 1'b0;
   always_ff @(posedge clk) begin
      if (rst) cam_y <= '0;
      else if (frame_start) cam_y <= target;
   end
`else
   localparam logic [PHY_WIDTH:0] STEP = (PHY_WIDTH+1)'(SCROLL_STEP);
   localparam logic [PHY_WIDTH:0] DZ   = (PHY_WIDTH+1)'(DEAD_ZONE);
   typedef enum logic [1:0] {HOLD, SCROLL_UP, SCROLL_DOWN} state_t;
   state_t state, nxt;
   logic [PHY_WIDTH:0] diff, step;
   logic up, moving;
   // The dead zone only gates starting a scroll; once moving, converge exactly
   always_comb begin
      up     = target > cam_y;
      diff   = up ? {1'b0, target} - {1'b0, cam_y} : {1'b0, cam_y} - {1'b0, target};
      step   = diff < STEP ? diff : STEP;
      moving = state == HOLD ? diff > DZ : diff != '0;
      nxt    = !moving ? HOLD : (state != HOLD && step == diff) ? HOLD : up ? SCROLL_UP : SCROLL_DOWN;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HOLD;
         scrolling <= 1'b0;
         cam_y     <= '0;
      end else if (frame_start) begin
         state     <= nxt;
         scrolling <= nxt != HOLD;
         if (moving) cam_y <= up ? cam_y + step[PHY_WIDTH-1:0] : cam_y - step[PHY_WIDTH-1:0];
      end
   end
`endif
endmodule

// File: tb/tb_map_view_ctrl.sv
// tb_map_view_ctrl: randomized + directed check of map_view_ctrl against a behavioural model
module tb_map_view_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [9:0] h_cnt = '0, v_cnt = '0;
   logic video_on = 1'b0, frame_start = 1'b0;
   logic [13:0] player_y = '0;
   logic [13:0] map_x, map_y, cam_y;
   logic map_on, scrolling;
   int total = 0, bad = 0;
   int m_cam = 0;
   bit m_sc = 1'b0;

   map_view_ctrl dut (
      .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .video_on(video_on),
      .frame_start(frame_start), .player_y(player_y), .map_x(map_x), .map_y(map_y),
      .map_on(map_on), .cam_y(cam_y), .scrolling(scrolling)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_frame(input int py);
      int t, d;
      t = py < 240 ? 0 : (py - 240 > 1920 ? 1920 : py - 240);
`ifdef MAP_VIEW_SNAP_EN
      d = 0;
      m_cam = t;
      m_sc = 1'b0;
`else
      d = t > m_cam ? t - m_cam : m_cam - t;
      if (m_sc ? d != 0 : d > 32) begin
         m_cam += (t > m_cam ? 1 : -1) * (d < 4 ? d : 4);
         m_sc = m_cam != t;
      end else m_sc = 1'b0;
`endif
   endtask

   task automatic frame(input int py);
      player_y = 14'(py);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      model_frame(py);
      chk("cam_y", cam_y, m_cam);
      chk("scrolling", scrolling, m_sc);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_cam = 0;
      m_sc = 1'b0;
      chk("rst_cam", cam_y, 0);
      chk("rst_scr", scrolling, 0);
   endtask

   task automatic pix(input int h, input int v, input bit von);
      bit win;
      h_cnt = 10'(h);
      v_cnt = 10'(v);
      video_on = von;
      tick();
      win = von && h >= 80 && h < 560 && v < 480;
      chk("map_on", map_on, win);
      chk("map_x", map_x, win ? h - 80 : 0);
      chk("map_y", map_y, win ? m_cam + 479 - v : 0);
   endtask

   initial begin
      // reset, including reset winning over a coincident frame_start
      tick();
      tick();
      chk("rst_map_x", map_x, 0);
      chk("rst_map_y", map_y, 0);
      chk("rst_map_on", map_on, 0);
      chk("rst_cam0", cam_y, 0);
      chk("rst_scr0", scrolling, 0);
      player_y = 14'd1000;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("rst_vs_frame", cam_y, 0);
      rst = 1'b0;
      // low player and window edges
      frame(100);
      pix(80, 479, 1'b1);
      chk("edge_map_on", map_on, 1);
      pix(79, 479, 1'b1);
      pix(560, 479, 1'b1);
      pix(300, 200, 1'b0);
      pix(300, 480, 1'b1);
      // scroll up toward target 160
      for (int i = 1; i <= 40; i++) begin
         frame(400);
`ifndef MAP_VIEW_SNAP_EN
         chk("up_cam_const", cam_y, 4 * i);
`endif
      end
      chk("up_done_scr", scrolling, 0);
      pix(100, 0, 1'b1);
      chk("top_map_y", map_y, 639);
      chk("top_map_x", map_x, 20);
      // dead zone, then a short scroll ending with a 1-pixel step
      do_reset();
      frame(260);
      for (int i = 1; i <= 9; i++) frame(273);
      chk("dz_final", cam_y, 33);
      // clamp toward 1920, then reverse mid-scroll
      do_reset();
      for (int i = 0; i < 10; i++) frame(3000);
      for (int i = 0; i < 11; i++) frame(0);
      chk("rev_final", cam_y, 0);
      frame(16383);
      frame(3000);
`ifdef MAP_VIEW_SNAP_EN
      chk("snap_cam", cam_y, 1920);
`endif
      // randomized frames and pixels
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0: frame($urandom_range(0, 3000));
            1: frame(m_cam + 240 + $urandom_range(0, 80) - 40);
            2: frame($urandom_range(0, 16383));
            default: pix($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom_range(0, 1)));
         endcase
      end
      // reset mid-scroll
      do_reset();
      for (int i = 0; i < 3; i++) frame(2000);
      do_reset();
      pix(200, 100, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
